// File: rtl/abp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : abp_pkg
// Description : Shared types and constants for the Alternating Bit Protocol
//               receiver controller: controller state encoding, default ACK
//               magic byte, ACK byte offsets and the ACK byte generator.
// Revision    : 1.0 - initial release
// ============================================================================
package abp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELIVER  = 2'd1,
        ACK_SEND = 2'd2
    } rxctl_state_t;

    localparam logic [7:0] ACK_MAGIC_DEFAULT = 8'hA5;

    // Byte positions inside an ACK frame; every other byte is zero padding.
    localparam logic [7:0] ACK_OFS_MAGIC = 8'd0;
    localparam logic [7:0] ACK_OFS_BIT   = 8'd1;

    // Content of ACK byte 'idx' for a frame acknowledging 'ack_bit'.
    function automatic logic [7:0] ack_byte(input logic [7:0] idx,
                                            input logic [7:0] magic,
                                            input logic       ack_bit);
        logic [7:0] b;
        b = 8'h00;
        if (idx == ACK_OFS_MAGIC) begin
            b = magic;
        end else if (idx == ACK_OFS_BIT) begin
            b = {7'b0, ack_bit};
        end
        return b;
    endfunction

endpackage : abp_pkg
`default_nettype wire

// File: rtl/abp_ack_framer.sv
`default_nettype none
// ============================================================================
// Module      : abp_ack_framer
// Description : Serializes one fixed-length ACK frame onto an 8-bit
//               AXI-Stream master each time it is started.
//   aclk, aresetn      clock, asynchronous active-low reset
//   i_start            one-cycle pulse: begin a frame (first beat valid next cycle)
//   i_ack_bit          bit to acknowledge; sampled with i_start
//   m_axis_*           registered AXI-Stream master (tvalid/tready/tlast/tdata)
//   o_done             pulse on the handshake of the final byte
// Revision    : 1.0 - initial release
// ============================================================================
module abp_ack_framer
    import abp_pkg::*;
#(
    parameter int         ACK_BYTES = 8,
    parameter logic [7:0] ACK_MAGIC = ACK_MAGIC_DEFAULT
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       i_start,
    input  logic       i_ack_bit,
    input  logic       m_axis_tready,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       o_done
);

    localparam logic [7:0] c_last_idx = 8'(ACK_BYTES - 1);

    logic [7:0] r_idx;
    logic       r_ack_bit;
    logic       w_beat;
    logic [7:0] w_idx_next;

    assign w_beat     = m_axis_tvalid & m_axis_tready;
    assign w_idx_next = r_idx + 8'd1;
    assign o_done     = w_beat & m_axis_tlast;

    // tdata/tlast are only updated on a start or an accepted beat, so they
    // hold steady for as long as the consumer stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_idx         <= 8'd0;
            r_ack_bit     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= 8'h00;
        end else if (i_start) begin
            r_idx         <= 8'd0;
            r_ack_bit     <= i_ack_bit;
            m_axis_tvalid <= 1'b1;
            // Frames are at least two bytes long, so beat 0 is never last.
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= ack_byte(8'd0, ACK_MAGIC, i_ack_bit);
        end else if (w_beat) begin
            if (m_axis_tlast) begin
                r_idx         <= 8'd0;
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tdata  <= 8'h00;
            end else begin
                r_idx         <= w_idx_next;
                m_axis_tlast  <= (w_idx_next == c_last_idx);
                m_axis_tdata  <= ack_byte(w_idx_next, ACK_MAGIC, r_ack_bit);
            end
        end
    end

endmodule : abp_ack_framer
`default_nettype wire

// File: rtl/abp_receiver_controller.sv
`default_nettype none
// ============================================================================
// Module      : abp_receiver_controller
// Description : Receiver-side Alternating Bit Protocol sequencer. Accepts
//               per-packet results, delivers new values to the application,
//               and answers every packet (new or duplicate) with an ACK frame.
//   aclk, aresetn          clock, asynchronous active-low reset
//   rx_valid/rx_bit/rx_value  completed packet pulse, its bit and payload
//   expected_bit           bit the next new packet must carry
//   app_tvalid/tready/tdata   value delivery to the application
//   m_axis_*               ACK frame stream toward the link transmitter
//   ack_count/dup_count/drop_count  saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module abp_receiver_controller
    import abp_pkg::*;
#(
    parameter int         ACK_BYTES = 8,
    parameter logic [7:0] ACK_MAGIC = ACK_MAGIC_DEFAULT,
    parameter int         CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             rx_valid,
    input  logic             rx_bit,
    input  logic [63:0]      rx_value,
    output logic             expected_bit,
    output logic             app_tvalid,
    input  logic             app_tready,
    output logic [63:0]      app_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [7:0]       m_axis_tdata,
    output logic [CNT_W-1:0] ack_count,
    output logic [CNT_W-1:0] dup_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    rxctl_state_t r_state;
    rxctl_state_t w_state_next;
    logic         w_accept;
    logic         w_dup;
    logic         w_deliver_done;
    logic         w_drop;
    logic         w_start;
    logic         w_start_bit;
    logic         w_frame_done;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The framer is started on the transition edge itself so the first ACK
    // beat is valid in the very first ACK_SEND cycle.
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_dup          = 1'b0;
        w_deliver_done = 1'b0;
        w_drop         = 1'b0;
        w_start        = 1'b0;
        w_start_bit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_bit == expected_bit) begin
                        w_accept     = 1'b1;
                        w_state_next = DELIVER;
                    end else begin
                        w_dup        = 1'b1;
                        w_start      = 1'b1;
                        w_start_bit  = rx_bit;
                        w_state_next = ACK_SEND;
                    end
                end
            end
            DELIVER: begin
                w_drop = rx_valid;
                if (app_tvalid && app_tready) begin
                    w_deliver_done = 1'b1;
                    w_start        = 1'b1;
                    w_start_bit    = expected_bit;
                    w_state_next   = ACK_SEND;
                end
            end
            ACK_SEND: begin
                w_drop = rx_valid;
                if (w_frame_done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            expected_bit <= 1'b0;
            app_tvalid   <= 1'b0;
            app_tdata    <= 64'd0;
        end else if (w_accept) begin
            app_tvalid <= 1'b1;
            app_tdata  <= rx_value;
        end else if (w_deliver_done) begin
            app_tvalid   <= 1'b0;
            expected_bit <= ~expected_bit;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ack_count  <= '0;
            dup_count  <= '0;
            drop_count <= '0;
        end else begin
            if (w_frame_done && (ack_count != c_cnt_max)) begin
                ack_count <= ack_count + c_cnt_one;
            end
            if (w_dup && (dup_count != c_cnt_max)) begin
                dup_count <= dup_count + c_cnt_one;
            end
            if (w_drop && (drop_count != c_cnt_max)) begin
                drop_count <= drop_count + c_cnt_one;
            end
        end
    end

    abp_ack_framer #(
        .ACK_BYTES (ACK_BYTES),
        .ACK_MAGIC (ACK_MAGIC)
    ) u_framer (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .i_start       (w_start),
        .i_ack_bit     (w_start_bit),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .o_done        (w_frame_done)
    );

endmodule : abp_receiver_controller
`default_nettype wire
